// File: rtl/bicubic_tap_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the bicubic tap sequencer.
// Weight codes select fixed kernel weights; the clamp maps the accumulator to a pixel.
package bicubic_pkg;

  localparam int NTAPS = 4;
  localparam int PIX_W = 8;
  localparam int ACC_W = 11;

  localparam logic [2:0] W_1P5  = 3'd0;
  localparam logic [2:0] W_8P5  = 3'd1;
  localparam logic [2:0] W_9    = 3'd2;
  localparam logic [2:0] W_14   = 3'd3;
  localparam logic [2:0] W_14P5 = 3'd4;
  localparam logic [2:0] W_54P5 = 3'd5;
  localparam logic [2:0] W_96   = 3'd6;
  localparam logic [2:0] W_124  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Weights are in 1/128 steps with half-step entries, so return them in 1/256 units.
  function automatic logic [7:0] weight_x256(input logic [2:0] code);
    case (code)
      W_1P5:   weight_x256 = 8'd3;
      W_8P5:   weight_x256 = 8'd17;
      W_9:     weight_x256 = 8'd18;
      W_14:    weight_x256 = 8'd28;
      W_14P5:  weight_x256 = 8'd29;
      W_54P5:  weight_x256 = 8'd109;
      W_96:    weight_x256 = 8'd192;
      default: weight_x256 = 8'd248;
    endcase
  endfunction

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])
      clamp_pix = '0;
    else if (|a[ACC_W-2:PIX_W])
      clamp_pix = '1;
    else
      clamp_pix = a[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/bicubic_tap_sequencer_if.sv
// Job input and pixel output handshake bundle of the bicubic tap sequencer.
interface bicubic_tap_sequencer_if;
  import bicubic_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [NTAPS*PIX_W-1:0] in_pix;
  logic [NTAPS*3-1:0]     in_wcode;
  logic [NTAPS-1:0]       in_wsign;
  logic                   out_valid;
  logic                   out_ready;
  logic [PIX_W-1:0]       out_pixel;

  modport slave (
    input  in_valid, in_pix, in_wcode, in_wsign, out_ready,
    output in_ready, out_valid, out_pixel
  );

  modport master (
    output in_valid, in_pix, in_wcode, in_wsign, out_ready,
    input  in_ready, out_valid, out_pixel
  );

endinterface

// File: rtl/bicubic_tap_sequencer_mult.sv
// Signed-magnitude pixel-by-weight multiplier; product truncated to 8 bits.
// A zero product is always reported as positive.
module bicubic_mult
  import bicubic_pkg::*;
(
  input  logic [PIX_W-1:0] pixel_i,
  input  logic [2:0]       wcode_i,
  input  logic             wsign_i,
  input  logic             pixel_sign_i,
  output logic [PIX_W-1:0] prod_mag_o,
  output logic             prod_sign_o
);

  logic [2*PIX_W-1:0] full;

  assign full        = {{PIX_W{1'b0}}, pixel_i} * {{PIX_W{1'b0}}, weight_x256(wcode_i)};
  assign prod_mag_o  = PIX_W'(full >> 8);
  assign prod_sign_o = (wsign_i ^ pixel_sign_i) & (|prod_mag_o);

endmodule

// File: rtl/bicubic_tap_sequencer.sv
// Sequences the four taps of one bicubic job through a single multiplier,
// accumulating signed products and returning one clamped output pixel.
module bicubic_tap_sequencer
  import bicubic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  bicubic_tap_sequencer_if.slave    bus
);

  state_e                   state_q, state_d;
  logic [1:0]               tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [NTAPS*PIX_W-1:0]   pix_q, pix_d;
  logic [NTAPS*3-1:0]       wcode_q, wcode_d;
  logic [NTAPS-1:0]         wsign_q, wsign_d;
  logic [PIX_W-1:0]         out_pixel_q, out_pixel_d;
  logic                     in_ready, out_valid, load;

  logic [PIX_W-1:0]         pix_tap   [NTAPS];
  logic [2:0]               wcode_tap [NTAPS];
  logic [PIX_W-1:0]         sel_pix, prod_mag;
  logic [2:0]               sel_wcode;
  logic                     sel_wsign, prod_sign;

  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      assign pix_tap[gi]   = pix_q[gi*PIX_W +: PIX_W];
      assign wcode_tap[gi] = wcode_q[gi*3 +: 3];
    end
  endgenerate

  assign sel_pix   = pix_tap[tap_q];
  assign sel_wcode = wcode_tap[tap_q];
  assign sel_wsign = wsign_q[tap_q];

  bicubic_mult u_mult (
    .pixel_i      (sel_pix),
    .wcode_i      (sel_wcode),
    .wsign_i      (sel_wsign),
    .pixel_sign_i (1'b0),
    .prod_mag_o   (prod_mag),
    .prod_sign_o  (prod_sign)
  );

  assign acc_sum = prod_sign ? acc_q - $signed({3'b000, prod_mag})
                             : acc_q + $signed({3'b000, prod_mag});

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    pix_d       = pix_q;
    wcode_d     = wcode_q;
    wsign_d     = wsign_q;
    out_pixel_d = out_pixel_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        load     = bus.in_valid;
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 2'd1;
        // The last tap's product is folded in before clamping, not after.
        if (tap_q == 2'(NTAPS-1)) begin
          state_d     = OUT;
          out_pixel_d = clamp_pix(acc_sum);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          load    = bus.in_valid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = MAC;
      tap_d   = 2'd0;
      acc_d   = '0;
      pix_d   = bus.in_pix;
      wcode_d = bus.in_wcode;
      wsign_d = bus.in_wsign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      pix_q       <= '0;
      wcode_q     <= '0;
      wsign_q     <= '0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      pix_q       <= pix_d;
      wcode_q     <= wcode_d;
      wsign_q     <= wsign_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pixel = out_pixel_q;

endmodule

// File: tb/tb_bicubic_tap_sequencer.sv
// Directed and randomized jobs against a kernel-arithmetic reference model,
// covering latency, clamping, backpressure, back-to-back accept and mid-job reset.
module tb_bicubic_tap_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   job_no;

  // Kernel weights in 1/256 units (i.e. twice the 1/128 weights).
  localparam int W256 [8] = '{3, 17, 18, 28, 29, 109, 192, 248};

  bicubic_tap_sequencer_if bus ();

  bicubic_tap_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input logic [31:0] pix, input logic [11:0] code, input logic [3:0] sign);
    int acc;
    int p;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      p = (int'(pix[8*k +: 8]) * W256[code[3*k +: 3]]) / 256;
      if (p > 255) p = p % 256;
      if (sign[k]) acc -= p;
      else         acc += p;
    end
    if (acc < 0)   acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  task automatic present(input logic [31:0] pix, input logic [11:0] code, input logic [3:0] sign);
    bus.in_pix   = pix;
    bus.in_wcode = code;
    bus.in_wsign = sign;
    bus.in_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus.in_pix   = $urandom;
    bus.in_wcode = 12'($urandom);
    bus.in_wsign = 4'($urandom);
  endtask

  // Called #1 after an edge with the DUT idle; leaves it idle again.
  task automatic do_job(input logic [31:0] pix, input logic [11:0] code, input logic [3:0] sign,
                        input int stall, input string tag);
    int exp;
    int held;
    exp = model(pix, code, sign);
    check_val({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
    present(pix, code, sign);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    check_val({tag, "_busy_E"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_noaccept_E"}, 32'(bus.in_ready), 32'd0);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      check_val({tag, "_busy"}, 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_pixel"}, 32'(bus.out_pixel), 32'(exp));
    held = int'(bus.out_pixel);
    $display("job %0d %s pix=%h code=%h sign=%b -> %0d (model %0d)",
             job_no, tag, pix, code, sign, bus.out_pixel, exp);
    job_no++;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_val({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      check_val({tag, "_stall_hold"}, 32'(bus.out_pixel), 32'(held));
      check_val({tag, "_stall_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] pix_a, pix_b;
    logic [11:0] code_a, code_b;
    logic [3:0]  sign_a, sign_b;
    int          exp_a, exp_b;

    n_cmp = 0;
    n_err = 0;
    job_no = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_out_pixel", 32'(bus.out_pixel), 32'd0);

    do_job({4{8'd128}}, {4{3'd6}}, 4'b0000, 0, "sat_high");
    do_job({4{8'd100}}, {3'd2, 3'd5, 3'd5, 3'd2}, 4'b1001, 0, "mixed");
    do_job({4{8'd200}}, {4{3'd7}}, 4'b1111, 0, "sat_low");
    do_job({4{8'd0}}, 12'($urandom), 4'b1111, 0, "zero");

    // Backpressure in OUT with a queued job, then accept on the release edge.
    pix_a = {8'd10, 8'd200, 8'd150, 8'd30};  code_a = {3'd1, 3'd6, 3'd5, 3'd0}; sign_a = 4'b1000;
    pix_b = {8'd255, 8'd255, 8'd40, 8'd90};  code_b = {3'd3, 3'd5, 3'd7, 3'd4}; sign_b = 4'b0010;
    exp_a = model(pix_a, code_a, sign_a);
    exp_b = model(pix_b, code_b, sign_b);
    present(pix_a, code_a, sign_a);
    @(posedge clk); #1;
    present(pix_b, code_b, sign_b);
    repeat (4) @(posedge clk);
    #1;
    check_val("bp_valid", 32'(bus.out_valid), 32'd1);
    check_val("bp_pixel", 32'(bus.out_pixel), 32'(exp_a));
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check_val("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check_val("bp_hold_pixel", 32'(bus.out_pixel), 32'(exp_a));
      check_val("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check_val("b2b_ready_comb", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    scramble_inputs();
    $display("job %0d backpressured pix=%h -> %0d (model %0d)", job_no, pix_a, exp_a, exp_a);
    job_no++;
    for (int c = 0; c < 4; c++) begin
      check_val("b2b_busy", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check_val("b2b_valid", 32'(bus.out_valid), 32'd1);
    check_val("b2b_pixel", 32'(bus.out_pixel), 32'(exp_b));
    $display("job %0d back_to_back pix=%h -> %0d (model %0d)", job_no, pix_b, bus.out_pixel, exp_b);
    job_no++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset while tap 2 is being accumulated; the job must vanish.
    present({4{8'd250}}, {4{3'd6}}, 4'b0000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("midrst_out_pixel", 32'(bus.out_pixel), 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
      check_val("midrst_no_output", 32'(bus.out_valid), 32'd0);
    end
    do_job({4{8'd100}}, {3'd2, 3'd5, 3'd5, 3'd2}, 4'b1001, 0, "after_rst");

    for (int j = 0; j < 30; j++) begin
      do_job($urandom, 12'($urandom), 4'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
